// File: rtl/iob_ram_sp_be_bist.sv
// BIST initiator for a single-port byte-enable RAM: full-word write pass, single-lane
// inverted overwrite pass, then pipelined read-back compare with first-failure capture.
module iob_ram_sp_be_bist #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int SEED   = 32
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [ADDR_W-1:0]   err_addr_o,
  output logic                ram_en_o,
  output logic [DATA_W/8-1:0] ram_we_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_d_o,
  input  logic [DATA_W-1:0]   ram_d_i
);

  localparam int NB = DATA_W / 8;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((2 ** ADDR_W) - 1);

  typedef enum logic [2:0] {IDLE, WR_FULL, WR_LANE, RD, DRAIN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  cnt_a;
  logic [ADDR_W-1:0]  cnt_a_inc;
  logic [ADDR_W-1:0]  cmp_addr;
  logic               cmp_valid;
  logic               cmp_fail;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) + DATA_W'(SEED);
  endfunction

  function automatic logic [NB-1:0] lane_we(input logic [ADDR_W-1:0] a);
    return NB'(1) << (int'(a) % NB);
  endfunction

  // Final word content: the lane written in the second pass holds the inverted byte.
  function automatic logic [DATA_W-1:0] expect_word(input logic [ADDR_W-1:0] a);
    return pat(a) ^ (DATA_W'(8'hFF) << (8 * (int'(a) % NB)));
  endfunction

  assign cnt_a     = cnt[ADDR_W-1:0];
  assign cnt_a_inc = cnt_a + ADDR_W'(1);

  // Read data lags the address by one cycle, so RD compares the previous address
  // and DRAIN picks up the last one.
  always_comb begin
    cmp_valid = 1'b0;
    cmp_addr  = cnt_a - ADDR_W'(1);
    if (state == DRAIN) begin
      cmp_valid = 1'b1;
      cmp_addr  = '1;
    end else if (state == RD && cnt != '0) begin
      cmp_valid = 1'b1;
    end
  end

  assign cmp_fail = cmp_valid && (ram_d_i != expect_word(cmp_addr));

  // All RAM and status outputs are loaded together with the state they belong to.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state      <= IDLE;
      cnt        <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      pass_o     <= 1'b0;
      err_addr_o <= '0;
      ram_en_o   <= 1'b0;
      ram_we_o   <= '0;
      ram_addr_o <= '0;
      ram_d_o    <= '0;
    end else if (cmp_fail) begin
      state      <= DONE;
      busy_o     <= 1'b0;
      done_o     <= 1'b1;
      pass_o     <= 1'b0;
      err_addr_o <= cmp_addr;
      ram_en_o   <= 1'b0;
      ram_we_o   <= '0;
      ram_addr_o <= '0;
      ram_d_o    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state      <= WR_FULL;
            cnt        <= '0;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            err_addr_o <= '0;
            ram_en_o   <= 1'b1;
            ram_we_o   <= '1;
            ram_addr_o <= '0;
            ram_d_o    <= pat('0);
          end
        end
        WR_FULL: begin
          if (cnt == LAST) begin
            state      <= WR_LANE;
            cnt        <= '0;
            ram_we_o   <= lane_we('0);
            ram_addr_o <= '0;
            ram_d_o    <= ~pat('0);
          end else begin
            cnt        <= cnt + CNT_W'(1);
            ram_addr_o <= cnt_a_inc;
            ram_d_o    <= pat(cnt_a_inc);
          end
        end
        WR_LANE: begin
          if (cnt == LAST) begin
            state      <= RD;
            cnt        <= '0;
            ram_we_o   <= '0;
            ram_addr_o <= '0;
            ram_d_o    <= '0;
          end else begin
            cnt        <= cnt + CNT_W'(1);
            ram_we_o   <= lane_we(cnt_a_inc);
            ram_addr_o <= cnt_a_inc;
            ram_d_o    <= ~pat(cnt_a_inc);
          end
        end
        RD: begin
          if (cnt == LAST) begin
            state      <= DRAIN;
            cnt        <= '0;
            ram_en_o   <= 1'b0;
            ram_addr_o <= '0;
          end else begin
            cnt        <= cnt + CNT_W'(1);
            ram_addr_o <= cnt_a_inc;
          end
        end
        DRAIN: begin
          state      <= DONE;
          busy_o     <= 1'b0;
          done_o     <= 1'b1;
          pass_o     <= 1'b1;
          err_addr_o <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_ram_sp_be_bist.sv
// Randomised bench for iob_ram_sp_be_bist with a behavioural byte-enable RAM and
// fault injection (read-data corruption, ignored byte enables, mid-run reset).
module tb_iob_ram_sp_be_bist;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int SEED   = 32;
  localparam int N      = 16;
  localparam int NB     = 4;

  logic              clk_i = 1'b0;
  logic              arst_n_i = 1'b1;
  logic              start_i = 1'b0;
  logic              busy_o, done_o, pass_o;
  logic [ADDR_W-1:0] err_addr_o;
  logic              ram_en_o;
  logic [NB-1:0]     ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_d_o;
  logic [DATA_W-1:0] ram_d_i;

  int checks = 0;
  int failures = 0;

  // Fault-injection controls for the RAM model
  int corrupt_addr = N;
  int corrupt_bit = 0;
  bit ignore_be = 1'b0;
  bit scramble_mem = 1'b0;

  logic [DATA_W-1:0] mem [N];
  logic [DATA_W-1:0] q = '0;
  logic [ADDR_W-1:0] rd_addr_q = '0;
  logic [DATA_W-1:0] bmask;

  iob_ram_sp_be_bist #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEED(SEED)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_addr_o(err_addr_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_d_o(ram_d_o), .ram_d_i(ram_d_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural single-port RAM; optionally treats any byte enable as a full-word write.
  always_comb begin
    bmask = '0;
    for (int i = 0; i < NB; i++)
      if (ram_we_o[i] || (ignore_be && ram_we_o != '0)) bmask[8*i +: 8] = 8'hFF;
  end

  always @(posedge clk_i) begin
    if (scramble_mem) begin
      for (int i = 0; i < N; i++) mem[i] <= 32'hDEAD_0000 | 32'(i);
    end else if (ram_en_o) begin
      if (ram_we_o != '0)
        mem[ram_addr_o] <= (mem[ram_addr_o] & ~bmask) | (ram_d_o & bmask);
      q <= mem[ram_addr_o];
      rd_addr_q <= ram_addr_o;
    end
  end

  assign ram_d_i = q ^ ((int'(rd_addr_q) == corrupt_addr) ? (32'h1 << corrupt_bit) : 32'h0);

  // Reference: word a = a+SEED with byte lane (a mod NB) inverted.
  function automatic logic [31:0] model_word(input int a);
    logic [31:0] p;
    int l;
    p = 32'(a + SEED);
    l = a % NB;
    p[8*l +: 8] = ~p[8*l +: 8];
    return p;
  endfunction

  // First address whose read-back differs from the reference, -1 when none.
  function automatic int predict_fail(input int c_addr, input int c_bit, input bit ib);
    logic [31:0] stored;
    for (int a = 0; a < N; a++) begin
      stored = ib ? ~32'(a + SEED) : model_word(a);
      if (a == c_addr) stored = stored ^ (32'h1 << c_bit);
      if (stored != model_word(a)) return a;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int c_addr, input int c_bit, input bit ib, input int spurious);
    int ff, exp_edge, edge_n;
    bit seen;
    corrupt_addr = c_addr;
    corrupt_bit = c_bit;
    ignore_be = ib;
    ff = predict_fail(c_addr, c_bit, ib);
    exp_edge = (ff < 0 || ff == N - 1) ? 3 * N + 1 : 2 * N + 2 + ff;
    @(negedge clk_i) scramble_mem = 1'b1;
    @(negedge clk_i) begin scramble_mem = 1'b0; start_i = 1'b1; end
    @(negedge clk_i) start_i = 1'b0;
    checkOutput("busy_after_start", 64'(busy_o), 64'd1);
    checkOutput("done_clear_after_start", 64'(done_o), 64'd0);
    edge_n = 0;
    seen = 1'b0;
    while (edge_n < 200 && !seen) begin
      @(posedge clk_i);
      edge_n++;
      #1;
      if (done_o) seen = 1'b1;
      else start_i = (edge_n == spurious);
    end
    start_i = 1'b0;
    if (!seen) begin
      checkOutput("done_timeout", 64'd0, 64'd1);
    end else begin
      checkOutput("done_edge", 64'(edge_n), 64'(exp_edge));
      checkOutput("pass", 64'(pass_o), 64'(ff < 0));
      checkOutput("err_addr", 64'(err_addr_o), 64'(ff < 0 ? 0 : ff));
      checkOutput("idle_outputs", {busy_o, ram_en_o, ram_we_o, ram_addr_o, ram_d_o}, 64'd0);
      if (ff < 0) begin
        checkOutput("mem0", 64'(mem[0]), 64'h0000_00DF);
        checkOutput("mem5", 64'(mem[5]), 64'(model_word(5)));
        for (int a = 0; a < N; a++)
          if (mem[a] != model_word(a)) checkOutput("mem_word", 64'(mem[a]), 64'(model_word(a)));
      end
      if (ib) checkOutput("mem0_nobe", 64'(mem[0]), 64'hFFFF_FFDF);
    end
    corrupt_addr = N;
    ignore_be = 1'b0;
  endtask

  task automatic midRunReset();
    @(negedge clk_i) start_i = 1'b1;
    @(negedge clk_i) start_i = 1'b0;
    repeat (22) @(posedge clk_i);
    checkOutput("busy_before_reset", 64'(busy_o), 64'd1);
    checkOutput("en_before_reset", 64'(ram_en_o), 64'd1);
    #3 arst_n_i = 1'b0;
    #1;
    checkOutput("en_async_drop", 64'(ram_en_o), 64'd0);
    checkOutput("busy_async_drop", 64'(busy_o), 64'd0);
    checkOutput("outputs_async_zero",
                {busy_o, done_o, pass_o, err_addr_o, ram_en_o, ram_we_o, ram_addr_o, ram_d_o}, 64'd0);
    @(negedge clk_i) arst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checkOutput("idle_after_reset", {busy_o, done_o, ram_en_o}, 64'd0);
  endtask

  initial begin
    int ca, cb, sp;
    #2 arst_n_i = 1'b0;
    #1;
    checkOutput("reset_outputs",
                {busy_o, done_o, pass_o, err_addr_o, ram_en_o, ram_we_o, ram_addr_o, ram_d_o}, 64'd0);
    @(negedge clk_i) arst_n_i = 1'b1;
    @(negedge clk_i);
    checkOutput("idle_busy", 64'(busy_o), 64'd0);

    applyStimulus(N, 0, 1'b0, 0);
    applyStimulus(7, 0, 1'b0, 0);
    applyStimulus(N, 0, 1'b1, 0);
    midRunReset();
    applyStimulus(N, 0, 1'b0, 0);
    applyStimulus(N, 0, 1'b0, 10);
    applyStimulus(N - 1, 31, 1'b0, 0);
    applyStimulus(0, 5, 1'b0, 0);

    for (int k = 0; k < 10; k++) begin
      ca = $urandom_range(0, N);
      cb = $urandom_range(0, DATA_W - 1);
      sp = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0;
      applyStimulus(ca, cb, 1'b0, sp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
